// File: rtl/crypto_pkg.sv
// crypto_pkg
//   Shared types and helpers for the iterative Feistel engine.
//   - state_e        : engine sequencing states
//   - MODE_ENC/DEC   : operation mode encoding
//   - round_key()    : per-round key, (key + i) mod 2^h
//   - feistel_f()    : round function, rotl_h(x ^ rk, rot)
//   Helpers work on a MAX_H-wide container and take the half width h as an
//   argument, so one package serves every DATA_W up to 2*MAX_H.
package crypto_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int MAX_H = 64;

  typedef logic [MAX_H-1:0] word_t;

  // All-ones mask for the low h bits.
  function automatic word_t h_mask(input int unsigned h);
    if (h >= MAX_H) return '1;
    return (word_t'(1) << h) - word_t'(1);
  endfunction

  // Round key for round index i; the addition wraps mod 2^h.
  function automatic word_t round_key(input word_t key, input word_t i,
                                      input int unsigned h);
    return (key + i) & h_mask(h);
  endfunction

  // F(x, rk) = rotl_h(x ^ rk, rot), rotation confined to h bits.
  function automatic word_t feistel_f(input word_t x, input word_t rk,
                                      input int unsigned rot,
                                      input int unsigned h);
    word_t y;
    y = (x ^ rk) & h_mask(h);
    if (rot == 0) return y;
    return ((y << rot) | (y >> (h - rot))) & h_mask(h);
  endfunction

endpackage

// File: rtl/crypto_feistel_engine_round.sv
// crypto_feistel_round
//   One combinational Feistel round, usable in either direction.
//   Ports:
//     l, r     : current half-words
//     rk       : round key for this round
//     mode     : MODE_ENC or MODE_DEC
//     l_next,
//     r_next   : half-words after the round
//   Encrypt: L' = R, R' = L ^ F(R, rk)
//   Decrypt: R' = L, L' = R ^ F(L, rk)   (exact inverse of the encrypt round)
module crypto_feistel_round
  import crypto_pkg::*;
#(
  parameter int H   = 8,
  parameter int ROT = 1
) (
  input  logic [H-1:0] l,
  input  logic [H-1:0] r,
  input  logic [H-1:0] rk,
  input  logic         mode,
  output logic [H-1:0] l_next,
  output logic [H-1:0] r_next
);

  logic [H-1:0] f_in;
  logic [H-1:0] f_out;

  // The round function always consumes the half that passes through
  // unchanged, which is R when encrypting and L when decrypting.
  assign f_in  = (mode == MODE_ENC) ? r : l;
  assign f_out = H'(feistel_f(word_t'(f_in), word_t'(rk), ROT, H));

  always_comb begin
    // NOTE: both outputs get a value on every path so no latch is inferred.
    l_next = r;
    r_next = l ^ f_out;
    if (mode == MODE_DEC) begin
      l_next = r ^ f_out;
      r_next = l;
    end
  end

endmodule

// File: rtl/crypto_feistel_engine.sv
// crypto_feistel_engine
//   Iterative Feistel cipher, one round per clock, with a programmable key.
//   Parameters: DATA_W (even, >= 4), ROUNDS (1..255), ROT (0 <= ROT < DATA_W/2)
//   Ports:
//     clk          : clock, rising edge
//     rst          : synchronous active-high reset
//     data_in      : word sampled with an accepted request
//     enc, dec     : single-cycle encrypt / decrypt request
//     key_in       : key value, loaded when key_load is high in IDLE
//     key_load     : key register write strobe
//     data_out     : last completed result, held until the next completion
//     busy         : operation in progress (state != IDLE)
//     result_ready : one-cycle pulse, data_out valid
//     err          : one-cycle pulse after enc and dec both high in IDLE
module crypto_feistel_engine
  import crypto_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ROUNDS = 8,
  parameter int ROT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                enc,
  input  logic                dec,
  input  logic [DATA_W/2-1:0] key_in,
  input  logic                key_load,
  output logic [DATA_W-1:0]   data_out,
  output logic                busy,
  output logic                result_ready,
  output logic                err
);

  localparam int H  = DATA_W / 2;
  localparam int CW = $clog2(ROUNDS + 1);

  state_e          state_q;
  state_e          state_d;
  logic            mode_q;
  logic [CW-1:0]   cnt_q;
  logic [H-1:0]    key_q;
  logic [H-1:0]    l_q;
  logic [H-1:0]    r_q;
  logic [DATA_W-1:0] data_out_q;
  logic            err_q;

  logic            req_ok;
  logic            req_both;
  logic            last_round;
  logic [H-1:0]    rk;
  logic [H-1:0]    l_next;
  logic [H-1:0]    r_next;

  assign req_ok   = enc ^ dec;
  assign req_both = enc & dec;

  // Encrypt counts 0 up to ROUNDS-1, decrypt counts ROUNDS-1 down to 0.
  assign last_round = (mode_q == MODE_ENC) ? (cnt_q == CW'(ROUNDS - 1))
                                           : (cnt_q == '0);

  assign rk = H'(round_key(word_t'(key_q), word_t'(cnt_q), H));

  crypto_feistel_round #(
    .H   (H),
    .ROT (ROT)
  ) u_round (
    .l      (l_q),
    .r      (r_q),
    .rk     (rk),
    .mode   (mode_q),
    .l_next (l_next),
    .r_next (r_next)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_ok) state_d = RUN;
      RUN:     if (last_round) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here, key included, is reset so an aborted
    // operation leaves nothing behind.
    if (rst) begin
      mode_q     <= MODE_ENC;
      cnt_q      <= '0;
      key_q      <= '0;
      l_q        <= '0;
      r_q        <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && req_both;
      unique case (state_q)
        IDLE: begin
          // Key and request in the same cycle: the new key is in key_q by
          // the first RUN cycle, so the operation uses it.
          if (key_load) key_q <= key_in;
          if (req_ok) begin
            l_q    <= data_in[DATA_W-1:H];
            r_q    <= data_in[H-1:0];
            mode_q <= dec ? MODE_DEC : MODE_ENC;
            cnt_q  <= dec ? CW'(ROUNDS - 1) : '0;
          end
        end
        RUN: begin
          l_q <= l_next;
          r_q <= r_next;
          // The result lands at the edge entering DONE so it is valid in the
          // same cycle that result_ready is high.
          if (last_round) begin
            data_out_q <= {l_next, r_next};
          end else if (mode_q == MODE_ENC) begin
            cnt_q <= cnt_q + CW'(1);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out     = data_out_q;
  assign busy         = (state_q != IDLE);
  assign result_ready = (state_q == DONE);
  assign err          = err_q;

endmodule

// File: tb/tb_crypto_feistel_engine.sv
// tb_crypto_feistel_engine
//   Self-checking bench: six engine instances with different parameter sets
//   share one clock. Expected values come from a loop-based Feistel model.
module tb_crypto_feistel_engine;

  localparam int NCFG = 6;
  localparam int CFG_DW  [NCFG] = '{16, 16, 8,  8, 32, 32};
  localparam int CFG_R   [NCFG] = '{ 8,  1, 1, 16,  1, 16};
  localparam int CFG_ROT [NCFG] = '{ 1,  1, 3,  3, 15, 15};

  logic            clk;
  logic [NCFG-1:0] rst_v;
  logic [NCFG-1:0] enc_v;
  logic [NCFG-1:0] dec_v;
  logic [NCFG-1:0] key_load_v;
  logic [31:0]     data_bus;
  logic [31:0]     key_bus;
  wire  [NCFG-1:0] busy_v;
  wire  [NCFG-1:0] rdy_v;
  wire  [NCFG-1:0] err_v;
  wire  [31:0]     dout_v [NCFG];

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : cfg_g
    localparam int DW = CFG_DW[g];
    localparam int HW = DW / 2;
    logic [DW-1:0] d_out;
    crypto_feistel_engine #(
      .DATA_W (DW),
      .ROUNDS (CFG_R[g]),
      .ROT    (CFG_ROT[g])
    ) dut (
      .clk          (clk),
      .rst          (rst_v[g]),
      .data_in      (data_bus[DW-1:0]),
      .enc          (enc_v[g]),
      .dec          (dec_v[g]),
      .key_in       (key_bus[HW-1:0]),
      .key_load     (key_load_v[g]),
      .data_out     (d_out),
      .busy         (busy_v[g]),
      .result_ready (rdy_v[g]),
      .err          (err_v[g])
    );
    assign dout_v[g] = 32'(d_out);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int bits);
    if (bits >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int h,
                                       input int s);
    if (s == 0) return x;
    return ((x << s) | (x >> (h - s))) & mask_of(h);
  endfunction

  // Reference cipher straight from the round equations.
  function automatic logic [31:0] ref_cipher(input int cfg, input bit decrypt,
                                             input logic [31:0] w,
                                             input logic [31:0] key);
    int h = CFG_DW[cfg] / 2;
    logic [31:0] m = mask_of(h);
    logic [31:0] l = (w >> h) & m;
    logic [31:0] r = w & m;
    logic [31:0] rk, t;
    for (int k = 0; k < CFG_R[cfg]; k++) begin
      int i = decrypt ? CFG_R[cfg] - 1 - k : k;
      rk = (key + 32'(i)) & m;
      if (!decrypt) begin
        t = l ^ rotl(r ^ rk, h, CFG_ROT[cfg]);
        l = r;
        r = t;
      end else begin
        t = r ^ rotl(l ^ rk, h, CFG_ROT[cfg]);
        r = l;
        l = t;
      end
    end
    return ((l << h) | r) & mask_of(CFG_DW[cfg]);
  endfunction

  // Issues one request and follows it to completion. inj_kind 1 pulses enc
  // (with data inj_val) and 2 pulses key_load (key inj_val) mid-operation.
  task automatic run_op(input int g, input bit decrypt, input logic [31:0] data,
                        input bit load, input logic [31:0] key,
                        input int inj_kind, input logic [31:0] inj_val,
                        output logic [31:0] res, output int lat,
                        output int busy_cnt);
    @(negedge clk);
    data_bus = data;
    key_bus  = key;
    key_load_v[g] = load;
    if (decrypt) dec_v[g] = 1'b1;
    else         enc_v[g] = 1'b1;
    @(negedge clk);
    enc_v[g] = 1'b0;
    dec_v[g] = 1'b0;
    key_load_v[g] = 1'b0;
    lat = 1;
    busy_cnt = 0;
    err_seen = 0;
    while (!rdy_v[g] && lat <= CFG_R[g] + 4) begin
      busy_cnt += int'(busy_v[g]);
      err_seen += int'(err_v[g]);
      if (lat == 3 && inj_kind == 1) begin
        data_bus = inj_val;
        enc_v[g] = 1'b1;
      end
      if (lat == 3 && inj_kind == 2) begin
        key_bus = inj_val;
        key_load_v[g] = 1'b1;
      end
      @(negedge clk);
      enc_v[g] = 1'b0;
      key_load_v[g] = 1'b0;
      lat++;
    end
    check($sformatf("ready_seen_cfg%0d", g), 32'(rdy_v[g]), 32'd1);
    busy_cnt += int'(busy_v[g]);
    err_seen += int'(err_v[g]);
    res = dout_v[g];
    @(negedge clk);
    busy_cnt += int'(busy_v[g]);
  endtask

  task automatic op_check(input string tag, input int g, input bit decrypt,
                          input logic [31:0] data, input bit load,
                          input logic [31:0] key, input int inj_kind,
                          input logic [31:0] inj_val,
                          input logic [31:0] exp_res,
                          output logic [31:0] res);
    int lat, bc;
    run_op(g, decrypt, data, load, key, inj_kind, inj_val, res, lat, bc);
    check({tag, "_data"}, res, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(CFG_R[g] + 1));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(CFG_R[g] + 1));
  endtask

  initial begin
    logic [31:0] w, ct, pt, key, prev, res;
    int rdy_cnt;

    rst_v = '1;
    enc_v = '0;
    dec_v = '0;
    key_load_v = '0;
    data_bus = '0;
    key_bus = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("reset_busy_cfg%0d", g), 32'(busy_v[g]), 32'd0);
      check($sformatf("reset_ready_cfg%0d", g), 32'(rdy_v[g]), 32'd0);
      check($sformatf("reset_err_cfg%0d", g), 32'(err_v[g]), 32'd0);
      check($sformatf("reset_dout_cfg%0d", g), dout_v[g], 32'd0);
    end
    rst_v = '0;

    // Known-answer vectors, DATA_W=16 ROUNDS=1 ROT=1 key=0.
    op_check("kat_enc", 1, 1'b0, 32'h1234, 1'b1, 32'h00, 0, 0, 32'h347A, res);
    op_check("kat_dec", 1, 1'b1, 32'h347A, 1'b0, 32'h00, 0, 0, 32'h1234, res);

    // Default parameters, key 0xA5: 256-word round trip.
    key = 32'hA5;
    for (int n = 0; n < 256; n++) begin
      w = (n == 0) ? 32'h0 : ($urandom & 32'hFFFF);
      op_check("rt_enc", 0, 1'b0, w, n == 0, key, 0, 0,
               ref_cipher(0, 1'b0, w, key), ct);
      if (n == 0) check("zero_word_changes", 32'(ct != 32'h0), 32'd1);
      op_check("rt_dec", 0, 1'b1, ct, 1'b0, key, 0, 0, w, pt);
    end

    // enc and dec together in IDLE: err pulse only.
    prev = dout_v[0];
    @(negedge clk);
    data_bus = 32'hBEEF;
    enc_v[0] = 1'b1;
    dec_v[0] = 1'b1;
    @(negedge clk);
    enc_v[0] = 1'b0;
    dec_v[0] = 1'b0;
    check("both_err_pulse", 32'(err_v[0]), 32'd1);
    check("both_busy_low", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    check("both_err_clears", 32'(err_v[0]), 32'd0);
    check("both_busy_still_low", 32'(busy_v[0]), 32'd0);
    check("both_dout_held", dout_v[0], prev);

    // enc while busy is ignored, no err.
    w = $urandom & 32'hFFFF;
    op_check("enc_busy", 0, 1'b0, w, 1'b0, key, 1, 32'h5A5A,
             ref_cipher(0, 1'b0, w, key), res);
    check("enc_busy_no_err", 32'(err_seen), 32'd0);

    // key_load while busy is ignored, now and for the next operation.
    w = $urandom & 32'hFFFF;
    op_check("key_busy", 0, 1'b0, w, 1'b0, key, 2, 32'h3C,
             ref_cipher(0, 1'b0, w, key), res);
    w = $urandom & 32'hFFFF;
    op_check("key_busy_after", 0, 1'b0, w, 1'b0, key, 0, 0,
             ref_cipher(0, 1'b0, w, key), res);

    // Back-to-back key loads: the last one wins.
    @(negedge clk);
    key_bus = 32'h11;
    key_load_v[0] = 1'b1;
    @(negedge clk);
    key_bus = 32'h77;
    @(negedge clk);
    key_load_v[0] = 1'b0;
    key = 32'h77;
    w = $urandom & 32'hFFFF;
    op_check("key_last_wins", 0, 1'b0, w, 1'b0, 32'h0, 0, 0,
             ref_cipher(0, 1'b0, w, key), res);

    // Reset in the middle of an 8-round operation.
    @(negedge clk);
    data_bus = $urandom & 32'hFFFF;
    enc_v[0] = 1'b1;
    @(negedge clk);
    enc_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_dout", dout_v[0], 32'd0);
    check("abort_ready", 32'(rdy_v[0]), 32'd0);
    rdy_cnt = 0;
    repeat (CFG_R[0] + 4) begin
      @(negedge clk);
      rdy_cnt += int'(rdy_v[0]);
    end
    check("abort_no_ready", 32'(rdy_cnt), 32'd0);
    w = $urandom & 32'hFFFF;
    op_check("post_abort_key0", 0, 1'b0, w, 1'b0, 32'h0, 0, 0,
             ref_cipher(0, 1'b0, w, 32'h0), res);

    // Parameter sweep, key loaded together with the first request.
    for (int g = 2; g < NCFG; g++) begin
      key = $urandom & mask_of(CFG_DW[g] / 2);
      for (int n = 0; n < 64; n++) begin
        w = $urandom & mask_of(CFG_DW[g]);
        op_check($sformatf("sweep%0d_enc", g), g, 1'b0, w, n == 0, key, 0, 0,
                 ref_cipher(g, 1'b0, w, key), ct);
        op_check($sformatf("sweep%0d_dec", g), g, 1'b1, ct, 1'b0, key, 0, 0,
                 w, pt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crypto_feistel_engine.md
# crypto_feistel_engine

Parametrised, sequential successor to the 16-bit combinational crypto coprocessor. It encrypts or decrypts one DATA_W-bit word per request with an iterative Feistel cipher, one round per clock, and a programmable key register. A request/busy/result_ready handshake connects it to the CPU coprocessor port. Decryption exactly inverts encryption for any key and width.

## Interface
- DATA_W, 16: block width; even, ≥4; half width H = DATA_W/2
- ROUNDS, 8: Feistel rounds per operation, 1..255
- ROT, 1: left-rotate amount in round function, 0 ≤ ROT < H

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- data_in  in  DATA_W  plaintext or ciphertext, sampled on request
- enc  in  1  encrypt request, single-cycle
- dec  in  1  decrypt request, single-cycle
- key_in  in  H  key value
- key_load  in  1  load key_in into key register
- data_out  out  DATA_W  result; holds last result until the next completion
- busy  out  1  operation in progress
- result_ready  out  1  one-cycle pulse; data_out valid
- err  out  1  one-cycle pulse; request rejected

## Operation
- Split: L = word[DATA_W-1:H], R = word[H-1:0]; output is {L, R} after the final round; no final swap.
- Round key: rk_i = (key + i) mod 2^H.
- Round function: F(x, rk) = rotl_H(x XOR rk, ROT).
- Encrypt round i = 0..ROUNDS-1: L' = R, R' = L XOR F(R, rk_i).
- Decrypt round i = ROUNDS-1..0: R' = L, L' = R XOR F(L, rk_i).
- FSM IDLE → RUN → DONE → IDLE:
  - IDLE: a valid request (exactly one of enc/dec high) latches data_in, mode and the round counter (0 for encrypt, ROUNDS-1 for decrypt). Next state is RUN.
  - RUN: one round per cycle. The counter increments for encrypt and decrements for decrypt. After the ROUNDS-th round, the state goes to DONE.
  - DONE: data_out is updated, result_ready is high for this cycle, and the next state is IDLE.
- busy = (state != IDLE).
- Key register:
  - key_load is accepted only in IDLE.
  - If key_load and a request arrive in the same cycle, the new key is used for that operation.
  - key_load while busy is ignored; the key stays constant for the whole operation.
- Rejection:
  - enc and dec both high in IDLE: no operation starts, err pulses the next cycle, and the state stays IDLE.
  - enc or dec while busy: silently ignored, no err.
- Arithmetic: all round-key additions wrap mod 2^H; the round counter is ceil(log2(ROUNDS+1)) bits wide.

## Timing
- Reset values: data_out = 0, busy = 0, result_ready = 0, err = 0, key = 0, state = IDLE, counter = 0.
- A request sampled at edge N gives: busy high from cycle N+1 through N+ROUNDS+1; result_ready high in cycle N+ROUNDS+1 only; data_out valid from that cycle onward.
- Throughput: a new request is accepted in the first IDLE cycle, N+ROUNDS+2. Minimum spacing between requests is ROUNDS+2 cycles.
- rst mid-operation: the operation is aborted and all state returns to reset values on the next edge. No result_ready is produced and the key is cleared.
- Back-to-back key_load writes in IDLE: the last one wins.

## Structure
- Shared package crypto_pkg:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_ENC / MODE_DEC
  - functions round_key(key, i) and feistel_f(x, rk), parameterised by H
- Sub-module crypto_feistel_round: combinational single round with inputs L, R, rk and mode, and outputs L', R'. It is instantiated once; the top level holds the FSM, counter, key and data registers.

## Test plan
- Single encrypt, DATA_W=16, ROUNDS=1, ROT=1, key=0x00, data_in=0x1234:
  - data_out = 0x347A
  - result_ready pulses exactly 2 cycles after the request edge
  - busy is high for those 2 cycles
- Single decrypt, same configuration, data_in=0x347A: data_out = 0x1234.
- Round trip, default parameters, key=0xA5, 256 random words:
  - encrypt each word, then decrypt the result; the original is recovered every time
  - result_ready appears 9 cycles after each request, and no ciphertext equals its plaintext for the word 0x0000
- Hazards:
  - enc and dec in the same IDLE cycle: err pulses 1 cycle, busy stays 0, data_out is unchanged
  - enc while busy: ignored and does not disturb the result
  - key_load while busy: the key is unchanged and the result matches the old key
- Reset mid-operation at round 4 of 8:
  - the next cycle shows busy = 0, data_out = 0 and no result_ready
  - a subsequent encrypt with key 0 matches the reference model
- Parameter sweep DATA_W ∈ {8, 32}, ROUNDS ∈ {1, 16}, ROT = H-1: a round trip over 64 random words recovers the input, and latency is ROUNDS+1.
